// File: rtl/mem_access_if.sv
// Execute-bundle, data-SRAM and write-back signals of the memory-access stage.
// slave: the stage itself. master: the surrounding pipeline and memory.
interface mem_access_if;
  logic        e_valid;
  logic        e_ready;
  logic [31:0] ea;
  logic [31:0] eb;
  logic [4:0]  ern;
  logic        e_wreg;
  logic        e_load;
  logic        e_store;
  logic [1:0]  e_size;
  logic        e_sext;

  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        m_valid;
  logic        m_wreg;
  logic [4:0]  m_rn;
  logic [31:0] m_data;
  logic        m_exc;

  modport slave (
    input  e_valid, ea, eb, ern, e_wreg, e_load, e_store, e_size, e_sext,
    input  data_addr_ok, data_data_ok, data_rdata,
    output e_ready,
    output data_req, data_wr, data_addr, data_wstrb, data_wdata,
    output m_valid, m_wreg, m_rn, m_data, m_exc
  );

  modport master (
    output e_valid, ea, eb, ern, e_wreg, e_load, e_store, e_size, e_sext,
    output data_addr_ok, data_data_ok, data_rdata,
    input  e_ready,
    input  data_req, data_wr, data_addr, data_wstrb, data_wdata,
    input  m_valid, m_wreg, m_rn, m_data, m_exc
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores over the data-SRAM
// request/response handshake and produces one registered result per
// accepted instruction. Execute is stalled while a transaction is open.
module mem_access (
  input  logic     clk,
  input  logic     resetn,
  mem_access_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state, state_nx;
  logic        accept, is_mem, misaligned, issue, complete;
  logic [3:0]  strb_nx;
  logic [31:0] wdata_nx;
  logic [31:0] load_val;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Bundle fields needed after the request has been issued
  logic [1:0]  l_off;
  logic [1:0]  l_size;
  logic        l_sext;
  logic [4:0]  l_rn;
  logic        l_wreg;
  logic        l_store;

  assign bus.e_ready = (state == S_IDLE);

  // Accept decode and alignment check on the live execute bundle
  always_comb begin
    accept = bus.e_valid & (state == S_IDLE);
    is_mem = bus.e_load | bus.e_store;
    unique case (bus.e_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.ea[0];
      default: misaligned = |bus.ea[1:0];
    endcase
    issue = accept & is_mem & ~misaligned;
  end

  // Next-state logic and completion detect
  always_comb begin
    state_nx = state;
    complete = 1'b0;
    unique case (state)
      S_IDLE: if (issue) state_nx = S_REQ;
      S_REQ: begin
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            complete = 1'b1;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.data_data_ok) begin
          complete = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Byte enables and lane-replicated store data for the request
  always_comb begin
    unique case (bus.e_size)
      2'd0: begin
        strb_nx  = 4'b0001 << bus.ea[1:0];
        wdata_nx = {4{bus.eb[7:0]}};
      end
      2'd1: begin
        strb_nx  = bus.ea[1] ? 4'b1100 : 4'b0011;
        wdata_nx = {2{bus.eb[15:0]}};
      end
      default: begin
        strb_nx  = 4'b1111;
        wdata_nx = bus.eb;
      end
    endcase
    if (!bus.e_store) strb_nx = 4'b1111;
  end

  // Load lane select and extension from the response data
  always_comb begin
    rd_byte = bus.data_rdata[{l_off, 3'b000} +: 8];
    rd_half = l_off[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    unique case (l_size)
      2'd0:    load_val = {{24{l_sext & rd_byte[7]}}, rd_byte};
      2'd1:    load_val = {{16{l_sext & rd_half[15]}}, rd_half};
      default: load_val = bus.data_rdata;
    endcase
  end

  // Latch the bundle fields on accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      l_off   <= '0;
      l_size  <= '0;
      l_sext  <= 1'b0;
      l_rn    <= '0;
      l_wreg  <= 1'b0;
      l_store <= 1'b0;
    end else if (accept) begin
      l_off   <= bus.ea[1:0];
      l_size  <= bus.e_size;
      l_sext  <= bus.e_sext;
      l_rn    <= bus.ern;
      l_wreg  <= bus.e_wreg;
      l_store <= bus.e_store;
    end
  end

  // Memory request: raised on issue, held with payload until addr_ok
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.data_req   <= 1'b0;
      bus.data_wr    <= 1'b0;
      bus.data_addr  <= '0;
      bus.data_wstrb <= '0;
      bus.data_wdata <= '0;
    end else if (issue) begin
      bus.data_req   <= 1'b1;
      bus.data_wr    <= bus.e_store;
      bus.data_addr  <= {bus.ea[31:2], 2'b00};
      bus.data_wstrb <= strb_nx;
      bus.data_wdata <= wdata_nx;
    end else if ((state == S_REQ) && bus.data_addr_ok) begin
      bus.data_req   <= 1'b0;
    end
  end

  // Write-back result: immediate for ALU/misaligned ops, on completion otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.m_valid <= 1'b0;
      bus.m_wreg  <= 1'b0;
      bus.m_rn    <= '0;
      bus.m_data  <= '0;
      bus.m_exc   <= 1'b0;
    end else begin
      bus.m_valid <= 1'b0;
      if (accept && !issue) begin
        bus.m_valid <= 1'b1;
        bus.m_rn    <= bus.ern;
        bus.m_data  <= bus.ea;
        bus.m_exc   <= is_mem & misaligned;
        bus.m_wreg  <= bus.e_wreg & ~(is_mem & misaligned);
      end else if (complete) begin
        bus.m_valid <= 1'b1;
        bus.m_rn    <= l_rn;
        bus.m_data  <= l_store ? '0 : load_val;
        bus.m_exc   <= 1'b0;
        bus.m_wreg  <= l_wreg & ~l_store;
      end
    end
  end

endmodule
